pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register; the generic replacement for the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Moves one opaque payload of DATA_W bits from an upstream stage to a downstream stage using a valid/ready handshake.
- Includes a 1-entry skid buffer, so in_ready is registered and never depends combinationally on out_ready.
- Supports synchronous flush that turns the stage into a bubble, and keeps saturating bubble/flush performance counters.

Parameters:
- DATA_W, 160, payload width in bits (packed control + data fields).
- CNT_W, 16, width of each performance counter.
- BUBBLE_VAL, {DATA_W{1'b0}}, value presented on out_data whenever out_valid=0 (zero = NOP control encoding).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat this cycle
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  downstream beat valid
- out_ready  in  1  downstream accepts the beat (0 = downstream stall)
- out_data  out  DATA_W  payload to downstream
- flush  in  1  kill all held and arriving beats (control or data hazard)
- bubble_cnt  out  CNT_W  cycles with out_valid=0, saturating
- flush_cnt  out  CNT_W  cycles with flush=1, saturating
- clr_cnt  in  1  synchronous clear of both counters

Behaviour:
- Reset: main_valid=0, skid_valid=0, main_data=BUBBLE_VAL, skid_data=BUBBLE_VAL, bubble_cnt=0, flush_cnt=0. Therefore in_ready=1, out_valid=0, out_data=BUBBLE_VAL. A reset asserted mid-transfer discards all held beats immediately.
- Output assignments:
  - out_valid = main_valid; out_data = main_data.
  - in_ready = ~skid_valid (register-only path).
- Event definitions: acc = in_valid & in_ready; drn = out_valid & out_ready.
- Three states, encoded by {skid_valid, main_valid}:
  - EMPTY (00):
    - acc -> FULL, with main_data <= in_data.
  - FULL (01):
    - acc & drn -> FULL, with main_data <= in_data.
    - drn only -> EMPTY, with main_data <= BUBBLE_VAL.
    - acc only -> SKID, with skid_data <= in_data.
    - neither -> hold.
  - SKID (11), where in_ready=0:
    - drn -> FULL, with main_data <= skid_data and skid_data <= BUBBLE_VAL.
    - otherwise hold.
- Latency: 1 cycle from in to out when the stage is EMPTY or FULL-and-draining. Beats leave in strict FIFO order; no beat is duplicated or dropped except by flush.
- Flush, highest priority below reset:
  - Next state is EMPTY. main_data and skid_data are set to BUBBLE_VAL.
  - A beat offered in the same cycle (in_valid & in_ready) is discarded.
  - A drain in the same cycle still completes: downstream may sample out_data that cycle.
  - out_valid=0 from the next cycle on.
- Downstream stall (out_ready=0) with upstream streaming: the stage absorbs exactly 2 beats (FULL, then SKID), then holds in_ready=0.
- out_data is held stable while out_valid=1 and out_ready=0. The downstream interface obeys standard valid/ready rules.
- Counters:
  - bubble_cnt += 1 each cycle out_valid=0; flush_cnt += 1 each cycle flush=1.
  - Both saturate at 2^CNT_W-1 (no wrap).
  - clr_cnt takes priority over increment: the counter becomes 0 that cycle.
- in_data bits are never interpreted; the stage is width-agnostic.

Test Plan:
- Reset, then stream: after reset, check in_ready=1, out_valid=0, out_data=0. Drive in_valid=1 with in_data=0x11, 0x22, 0x33 on consecutive cycles and out_ready=1. Required: out_data=0x11, 0x22, 0x33 on cycles 1, 2, 3 with out_valid=1, and in_ready stays 1 throughout.
- Stall fill: out_ready=0 while offering 0xA, 0xB, 0xC. Required: 0xA and 0xB accepted; in_ready=0 from the cycle after 0xB; 0xC is held upstream. Then release out_ready=1. Required: out_data sequence 0xA, 0xB, 0xC with no loss.
- Flush in SKID: pulse flush=1 for one cycle while offering 0xD. Required: next cycle out_valid=0, out_data=0, in_ready=1; 0xD never appears at the output; flush_cnt=1.
- Flush with drain: flush=1 and out_ready=1 while in FULL holding 0x55. Required: downstream samples 0x55 that cycle; stage is EMPTY next cycle.
- Counters: set CNT_W=4 and idle for 20 cycles. Required: bubble_cnt saturates at 15. Then assert clr_cnt for 1 cycle. Required: bubble_cnt=0 that cycle and resumes counting afterwards.
- Async reset mid-SKID: assert rst asynchronously between clock edges while the stage is in SKID. Required: out_valid=0, in_ready=1 and both counters=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with a 1-entry skid buffer,
// synchronous flush and saturating bubble/flush performance counters.
module pipe_stage_reg #(
    parameter int                 DATA_W     = 160,
    parameter int                 CNT_W      = 16,
    parameter logic [DATA_W-1:0]  BUBBLE_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    input  logic              clr_cnt
);

    // Encoding is {skid_valid, main_valid}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] cnt,
        input logic             inc,
        input logic             clr
    );
        logic [CNT_W-1:0] res;
        if (clr) begin
            res = CNT_ZERO;
        end else if (inc && (cnt != CNT_MAX)) begin
            res = cnt + CNT_ONE;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [DATA_W-1:0] main_data_r;
    logic [DATA_W-1:0] main_data_nxt_s;
    logic [DATA_W-1:0] skid_data_r;
    logic [DATA_W-1:0] skid_data_nxt_s;
    logic [CNT_W-1:0]  bubble_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;
    logic              main_valid_s;
    logic              skid_valid_s;
    logic              acc_s;
    logic              drn_s;

    assign main_valid_s = (state_r == FULL) || (state_r == SKID);
    assign skid_valid_s = (state_r == SKID);
    assign acc_s        = in_valid & ~skid_valid_s;
    assign drn_s        = main_valid_s & out_ready;

    assign in_ready   = ~skid_valid_s;
    assign out_valid  = main_valid_s;
    assign out_data   = main_data_r;
    assign bubble_cnt = bubble_cnt_r;
    assign flush_cnt  = flush_cnt_r;

    // State and payload registers; reset drops any held beat at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= EMPTY;
            main_data_r <= BUBBLE_VAL;
            skid_data_r <= BUBBLE_VAL;
        end else begin
            state_r     <= state_nxt_s;
            main_data_r <= main_data_nxt_s;
            skid_data_r <= skid_data_nxt_s;
        end
    end

    // Next-state and payload steering; flush overrides every transition.
    always_comb begin
        state_nxt_s     = state_r;
        main_data_nxt_s = main_data_r;
        skid_data_nxt_s = skid_data_r;
        if (flush) begin
            state_nxt_s     = EMPTY;
            main_data_nxt_s = BUBBLE_VAL;
            skid_data_nxt_s = BUBBLE_VAL;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (acc_s) begin
                        state_nxt_s     = FULL;
                        main_data_nxt_s = in_data;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end
                FULL: begin
                    if (acc_s && drn_s) begin
                        state_nxt_s     = FULL;
                        main_data_nxt_s = in_data;
                    end else if (drn_s) begin
                        state_nxt_s     = EMPTY;
                        main_data_nxt_s = BUBBLE_VAL;
                    end else if (acc_s) begin
                        state_nxt_s     = SKID;
                        skid_data_nxt_s = in_data;
                    end else begin
                        state_nxt_s = FULL;
                    end
                end
                SKID: begin
                    // Skid entry slides into main; upstream stays blocked this cycle.
                    if (drn_s) begin
                        state_nxt_s     = FULL;
                        main_data_nxt_s = skid_data_r;
                        skid_data_nxt_s = BUBBLE_VAL;
                    end else begin
                        state_nxt_s = SKID;
                    end
                end
                default: begin
                    state_nxt_s     = EMPTY;
                    main_data_nxt_s = BUBBLE_VAL;
                    skid_data_nxt_s = BUBBLE_VAL;
                end
            endcase
        end
    end

    // Saturating performance counters; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_r <= CNT_ZERO;
            flush_cnt_r  <= CNT_ZERO;
        end else begin
            bubble_cnt_r <= sat_inc(bubble_cnt_r, ~main_valid_s, clr_cnt);
            flush_cnt_r  <= sat_inc(flush_cnt_r, flush, clr_cnt);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised scoreboard bench for pipe_stage_reg against a two-deep FIFO
// reference model with saturating counters.
module tb_pipe_stage_reg;

    localparam int DW = 160;
    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = 4'd15;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          flush;
    logic [CW-1:0] bubble_cnt;
    logic [CW-1:0] flush_cnt;
    logic          clr_cnt;

    pipe_stage_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .flush      (flush),
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt),
        .clr_cnt    (clr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] sb_q[$];
    logic [CW-1:0] m_bub;
    logic [CW-1:0] m_fl;

    function automatic void check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [DW-1:0] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Stage contents are just a FIFO of at most two beats.
    function automatic void check_outputs();
        logic [DW-1:0] exp_data;
        exp_data = (model_q.size() > 0) ? model_q[0] : {DW{1'b0}};
        check("in_ready",   DW'(in_ready),   DW'(model_q.size() < 2));
        check("out_valid",  DW'(out_valid),  DW'(model_q.size() > 0));
        check("out_data",   out_data,        exp_data);
        check("bubble_cnt", DW'(bubble_cnt), DW'(m_bub));
        check("flush_cnt",  DW'(flush_cnt),  DW'(m_fl));
    endfunction

    function automatic void model_cycle();
        int sz;
        bit acc;
        bit drn;
        sz  = model_q.size();
        acc = in_valid && (sz < 2);
        drn = (sz > 0) && out_ready;
        if (clr_cnt) m_bub = '0;
        else if (sz == 0 && m_bub != CMAX) m_bub = m_bub + 4'd1;
        if (clr_cnt) m_fl = '0;
        else if (flush && m_fl != CMAX) m_fl = m_fl + 4'd1;
        if (flush) begin
            model_q.delete();
            if (drn) begin
                while (sb_q.size() > 1) void'(sb_q.pop_back());
            end else begin
                sb_q.delete();
            end
        end else begin
            if (drn) void'(model_q.pop_front());
            if (acc) begin
                model_q.push_back(in_data);
                sb_q.push_back(in_data);
            end
        end
    endfunction

    task automatic step(input logic v, input logic [DW-1:0] d, input logic ordy,
                        input logic fl, input logic clr);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        clr_cnt   = clr;
        check_outputs();
        model_cycle();
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        flush     = 1'b0;
        clr_cnt   = 1'b0;
        check_outputs();
        model_cycle();
    endtask

    // Monitor: pops the scoreboard whenever a beat is handed downstream.
    initial begin
        logic          pv;
        logic          pr;
        logic [DW-1:0] pd;
        logic [DW-1:0] exp;
        pv = 1'b0;
        pr = 1'b0;
        pd = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr && out_valid) check("hold_stable", out_data, pd);
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_beat", out_data, {DW{1'bx}});
                    end else begin
                        exp = sb_q.pop_front();
                        check("out_beat", out_data, exp);
                    end
                end
                pv = out_valid;
                pr = out_ready;
                pd = out_data;
            end
        end
    end

    initial begin
        logic [DW-1:0] cur;
        bit            pend;
        bit            v;
        bit            acc_pre;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        clr_cnt   = 1'b0;
        m_bub     = '0;
        m_fl      = '0;
        release_reset();

        // Streaming through an empty stage.
        step(1'b1, 160'h11, 1'b1, 1'b0, 1'b0);
        step(1'b1, 160'h22, 1'b1, 1'b0, 1'b0);
        step(1'b1, 160'h33, 1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b0, 160'h0, 1'b1, 1'b0, 1'b0);

        // Downstream stall absorbs two beats, third is held upstream.
        step(1'b1, 160'hA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 160'hB, 1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b1, 160'hC, 1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b1, 160'hC, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 160'h0, 1'b1, 1'b0, 1'b0);

        // Flush while in SKID kills both held beats and the offered one.
        step(1'b0, 160'h0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 160'hA1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 160'hB1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 160'hD, 1'b0, 1'b1, 1'b0);
        repeat (2) step(1'b0, 160'h0, 1'b1, 1'b0, 1'b0);

        // Flush coinciding with a drain still delivers the held beat.
        step(1'b1, 160'h55, 1'b1, 1'b0, 1'b0);
        step(1'b0, 160'h0, 1'b1, 1'b1, 1'b0);
        repeat (2) step(1'b0, 160'h0, 1'b1, 1'b0, 1'b0);

        // Bubble counter saturation and clear.
        repeat (20) step(1'b0, 160'h0, 1'b1, 1'b0, 1'b0);
        check("bubble_sat", DW'(bubble_cnt), DW'(4'd15));
        step(1'b0, 160'h0, 1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b0, 160'h0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset while in SKID.
        step(1'b1, 160'hE1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 160'hE2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_outputs();
        #3 rst = 1'b1;
        #1;
        check("arst_out_valid",  DW'(out_valid),  DW'(1'b0));
        check("arst_in_ready",   DW'(in_ready),   DW'(1'b1));
        check("arst_out_data",   out_data,        {DW{1'b0}});
        check("arst_bubble_cnt", DW'(bubble_cnt), DW'(4'd0));
        check("arst_flush_cnt",  DW'(flush_cnt),  DW'(4'd0));
        model_q.delete();
        sb_q.delete();
        m_bub = '0;
        m_fl  = '0;
        release_reset();

        // Randomised traffic; upstream holds an unaccepted beat stable.
        pend = 1'b0;
        cur  = '0;
        for (int i = 0; i < 3000; i++) begin
            v = pend ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (!pend) cur = rand_data();
            acc_pre = (model_q.size() < 2);
            step(v, cur, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 49) == 0));
            pend = v && !acc_pre;
        end
        repeat (5) step(1'b0, 160'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #3;
        check("sb_empty", DW'(sb_q.size()), DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
